// File: rtl/fc_layer_seq.sv
// fc_layer_seq: collects IN activations into a registered vector that feeds a combinational
// FC layer. After a settle delay it captures the layer result and holds it until handshake.
// Latency: last accept at edge t, result captured at edge t+1+SETTLE. in_ready is low while
// waiting or holding a result, and out_data/vec stay frozen until out_ready.
//
// Ports:
//   clk, rst (async, active-high), flush (synchronous abort)
//   in_data/in_valid/in_ready : activation stream, index order 0..IN-1
//   vec                        : registered activation vector driving the layer x input
//   layer_z                    : layer result (post-ReLU) read back from the layer
//   out_data/out_valid/out_ready : captured result with valid/ready handshake
//   busy, frames               : status; frames counts completed result handshakes
module fc_layer_seq #(
   parameter int WIDTH   = 8,
   parameter int IN      = 84,
   parameter int O_WIDTH = 22,
   parameter int SETTLE  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [WIDTH-1:0]   in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH-1:0]   vec [0:IN-1],
   input  logic [O_WIDTH-1:0] layer_z,
   output logic [O_WIDTH-1:0] out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy,
   output logic [15:0]        frames
);

   localparam int AW = $clog2(IN);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      WAIT = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        count_q, count_d;
   logic [3:0]           settle_q, settle_d;
   logic [O_WIDTH-1:0]   out_data_q, out_data_d;
   logic [15:0]          frames_q, frames_d;
   logic [WIDTH-1:0]     vec_q [0:IN-1];
   logic                 accept;

   // Next-state logic. flush is checked first so it overrides both an
   // input acceptance and an output handshake in the same cycle.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      settle_d   = settle_q;
      out_data_d = out_data_q;
      frames_d   = frames_q;
      accept     = 1'b0;

      if (flush) begin
         state_d  = LOAD;
         count_d  = '0;
         settle_d = '0;
      end else begin
         case (state_q)
            LOAD: begin
               if (in_valid) begin
                  accept = 1'b1;
                  if (count_q == CW'(IN - 1)) begin
                     state_d  = WAIT;
                     count_d  = '0;
                     settle_d = 4'(SETTLE);
                  end else begin
                     count_d = count_q + 1'b1;
                  end
               end
            end
            WAIT: begin
               // Give the combinational layer SETTLE cycles on the new vector
               // before sampling its output.
               if (settle_q != 4'd0) begin
                  settle_d = settle_q - 4'd1;
               end else begin
                  out_data_d = layer_z;
                  state_d    = OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  state_d  = LOAD;
                  frames_d = frames_q + 16'd1;
               end
            end
            default: begin
               state_d = LOAD;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= LOAD;
         count_q    <= '0;
         settle_q   <= '0;
         out_data_q <= '0;
         frames_q   <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         settle_q   <= settle_d;
         out_data_q <= out_data_d;
         frames_q   <= frames_d;
      end
   end

   // Vector storage: only the accepted slot is written, so entries of the
   // previous frame persist until overwritten.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < IN; i++) begin
            vec_q[i] <= '0;
         end
      end else if (accept) begin
         vec_q[count_q[AW-1:0]] <= in_data;
      end
   end

   assign vec       = vec_q;
   assign in_ready  = (state_q == LOAD);
   assign out_valid = (state_q == OUT);
   assign out_data  = out_data_q;
   assign frames    = frames_q;
   assign busy      = (state_q != LOAD) || (count_q != '0);

endmodule
